// File: rtl/rhodonite_pkg.sv
// rhodonite_pkg: shared constants for the multicycle MIPS datapath front end.
package rhodonite_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [1:0] PC_SEL_ALU = 2'b00;
  localparam logic [1:0] PC_SEL_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD = 2'b11;
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int TARGET_W = 26;
  typedef enum logic {HS_IDLE, HS_BUSY} hs_state_e;
endpackage

// File: rtl/mem_handshake.sv
// mem_handshake: IDLE/BUSY req/ack sequencer with hold registers and stall;
// FETCH_MEM_TIMEOUT_EN adds a BUSY timeout that aborts and sets a sticky bus error.
module mem_handshake
  import rhodonite_pkg::*;
#(
  parameter int W = DATA_WIDTH
`ifdef FETCH_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES_P = 255
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_fetch,
  input  logic         i_load,
  input  logic         i_store,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_mem_ack,
  input  logic [W-1:0] i_mem_rdata,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  output logic         o_stall,
  output logic         o_cpl_fetch,
  output logic         o_cpl_load,
  output logic [W-1:0] o_cpl_data,
  output logic         o_bus_err
);
  hs_state_e state_q, state_d;
  logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d, fetch_q, fetch_d, load_q, load_d;
  logic busy, ack, done, timeout;
  always_comb begin
    busy = state_q == HS_BUSY;
    // reset is asynchronous, so the request must vanish combinationally too
    o_mem_req = busy | ((i_fetch | i_load | i_store) & ~reset);
    o_mem_addr = busy ? addr_q : i_addr;
    o_mem_we = busy ? we_q : i_store;
    o_mem_wdata = busy ? wdata_q : i_wdata;
    fetch_d = busy ? fetch_q : i_fetch;
    load_d = busy ? load_q : i_load;
    ack = o_mem_req & i_mem_ack;
    done = ack | timeout;
    o_stall = o_mem_req & ~done;
    o_cpl_fetch = done & fetch_d;
    o_cpl_load = done & load_d;
    o_cpl_data = ack ? i_mem_rdata : '0;
    state_d = o_stall ? HS_BUSY : HS_IDLE;
    addr_d = o_mem_addr;
    we_d = o_mem_we;
    wdata_d = o_mem_wdata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= HS_IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      fetch_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      fetch_q <= fetch_d;
      load_q <= load_d;
    end
`ifdef FETCH_MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES_P + 1) > 8) ? $clog2(TIMEOUT_CYCLES_P + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES_P - 1));
  assign o_bus_err = err_q;
  always_comb begin
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    err_d = err_q | (timeout & ~ack);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign timeout = 1'b0;
  assign o_bus_err = 1'b0;
`endif
endmodule

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: multicycle MIPS front end holding PC/IR/MDR/ALUOut over a shared memory port;
// FETCH_MEM_TIMEOUT_EN enables the memory timeout in mem_handshake.
module fetch_mem_unit
  import rhodonite_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter logic [DATA_WIDTH_P-1:0] RESET_PC_P = '0
`ifdef FETCH_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES_P = 255
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable_pc,
  input  logic                    i_branch,
  input  logic [1:0]              i_pc_next_sel,
  input  logic                    i_alu_zero,
  input  logic [DATA_WIDTH_P-1:0] i_alu_result,
  input  logic                    i_instr_data_addr_sel,
  input  logic                    i_instr_wr_en,
  input  logic                    i_instr_data_wr_en,
  input  logic                    i_mem_read_en,
  input  logic [DATA_WIDTH_P-1:0] i_wr_data,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0] o_mem_wdata,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH_P-1:0] i_mem_rdata,
  output logic                    o_stall,
  output logic [DATA_WIDTH_P-1:0] o_pc,
  output logic [DATA_WIDTH_P-1:0] o_instr,
  output logic [5:0]              o_opcode,
  output logic [5:0]              o_function,
  output logic [4:0]              o_rs,
  output logic [4:0]              o_rt,
  output logic [4:0]              o_rd,
  output logic [15:0]             o_imm,
  output logic [DATA_WIDTH_P-1:0] o_mem_data,
  output logic [DATA_WIDTH_P-1:0] o_alu_out,
  output logic                    o_bus_err
);
  logic [DATA_WIDTH_P-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, alu_out_q, alu_out_d;
  logic [DATA_WIDTH_P-1:0] pc_sel, cpl_data;
  logic cpl_fetch, cpl_load, pc_we;
  mem_handshake #(
    .W(DATA_WIDTH_P)
`ifdef FETCH_MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES_P(TIMEOUT_CYCLES_P)
`endif
  ) u_hs (
    .clk         (clk),
    .reset       (reset),
    .i_fetch     (i_instr_wr_en),
    .i_load      (i_mem_read_en & ~i_instr_wr_en),
    .i_store     (i_instr_data_wr_en & ~i_instr_wr_en),
    .i_addr      (i_instr_data_addr_sel ? alu_out_q : pc_q),
    .i_wdata     (i_wr_data),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_stall     (o_stall),
    .o_cpl_fetch (cpl_fetch),
    .o_cpl_load  (cpl_load),
    .o_cpl_data  (cpl_data),
    .o_bus_err   (o_bus_err)
  );
  always_comb begin
    pc_we = (i_enable_pc | (i_branch & i_alu_zero)) & ~o_stall;
    // jump target uses the pre-edge IR and the PC already advanced by the fetch
    pc_sel = i_pc_next_sel == PC_SEL_ALU     ? i_alu_result :
             i_pc_next_sel == PC_SEL_ALU_OUT ? alu_out_q :
             i_pc_next_sel == PC_SEL_JUMP    ? {pc_q[31:28], ir_q[TARGET_W-1:0], 2'b00} : pc_q;
    pc_d = pc_we ? pc_sel : pc_q;
    ir_d = cpl_fetch ? cpl_data : ir_q;
    mdr_d = cpl_load ? cpl_data : mdr_q;
    alu_out_d = o_stall ? alu_out_q : i_alu_result;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= RESET_PC_P;
      ir_q <= '0;
      mdr_q <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
      alu_out_q <= alu_out_d;
    end
  assign o_pc = pc_q;
  assign o_instr = ir_q;
  assign o_opcode = ir_q[OPCODE_LSB +: 6];
  assign o_rs = ir_q[RS_LSB +: 5];
  assign o_rt = ir_q[RT_LSB +: 5];
  assign o_rd = ir_q[RD_LSB +: 5];
  assign o_function = ir_q[5:0];
  assign o_imm = ir_q[15:0];
  assign o_mem_data = mdr_q;
  assign o_alu_out = alu_out_q;
endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: directed vector table, reset corners, randomized model comparison
// and (with FETCH_MEM_TIMEOUT_EN) the timeout abort sequence.
module tb_fetch_mem_unit;
  logic clk = 1'b0;
  logic reset;
  logic en, br, zero, as, f, l, s, ack;
  logic [1:0] sel;
  logic [31:0] alu, wd, rd;
  logic req, we, stall, bus_err;
  logic [31:0] addr, wdata, pc, instr, mdr, alu_out;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rdf;
  logic [15:0] imm;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_mem_unit #(
    .RESET_PC_P(32'h100)
`ifdef FETCH_MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES_P(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .i_enable_pc(en), .i_branch(br), .i_pc_next_sel(sel),
    .i_alu_zero(zero), .i_alu_result(alu), .i_instr_data_addr_sel(as),
    .i_instr_wr_en(f), .i_instr_data_wr_en(s), .i_mem_read_en(l), .i_wr_data(wd),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .i_mem_ack(ack), .i_mem_rdata(rd), .o_stall(stall), .o_pc(pc), .o_instr(instr),
    .o_opcode(opcode), .o_function(funct), .o_rs(rs), .o_rt(rt), .o_rd(rdf),
    .o_imm(imm), .o_mem_data(mdr), .o_alu_out(alu_out), .o_bus_err(bus_err)
  );

  typedef struct {
    logic [5:0] ctl;
    logic [1:0] sel;
    logic as;
    logic [31:0] alu, wd;
    logic ack;
    logic [31:0] rd;
    logic [2:0] e_rws;
    logic [31:0] e_addr, e_pc, e_ir, e_mdr, e_alu;
  } vec_t;
  vec_t tv[18];

  logic [31:0] m_pc, m_ir, m_mdr, m_alu, nxt_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [1:0] sl, input logic a,
                       input logic [31:0] al, input logic [31:0] w, input logic k,
                       input logic [31:0] r);
    {f, l, s, en, br, zero} = c;
    sel = sl; as = a; alu = al; wd = w; ack = k; rd = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(6'b0, 2'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    m_pc = 32'h100; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0;
  endtask

  initial begin
    tv = '{
      '{6'b100100, 2'b00, 1'b0, 32'h104, 32'h0, 1'b1, 32'h8C220004, 3'b100, 32'h100, 32'h104, 32'h8C220004, 32'h0, 32'h104},
      '{6'b000000, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3'b000, 32'h104, 32'h104, 32'h8C220004, 32'h0, 32'h40},
      '{6'b010100, 2'b00, 1'b1, 32'h999, 32'h0, 1'b0, 32'h0, 3'b101, 32'h40, 32'h104, 32'h8C220004, 32'h0, 32'h40},
      '{6'b010100, 2'b00, 1'b1, 32'h777, 32'h0, 1'b0, 32'h0, 3'b101, 32'h40, 32'h104, 32'h8C220004, 32'h0, 32'h40},
      '{6'b010100, 2'b00, 1'b1, 32'h555, 32'h0, 1'b0, 32'h0, 3'b101, 32'h40, 32'h104, 32'h8C220004, 32'h0, 32'h40},
      '{6'b010100, 2'b00, 1'b1, 32'h108, 32'h0, 1'b1, 32'h12345678, 3'b100, 32'h40, 32'h108, 32'h8C220004, 32'h12345678, 32'h108},
      '{6'b001000, 2'b00, 1'b1, 32'h50, 32'hDEADBEEF, 1'b0, 32'h0, 3'b111, 32'h108, 32'h108, 32'h8C220004, 32'h12345678, 32'h108},
      '{6'b001000, 2'b00, 1'b1, 32'h60, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFF, 3'b110, 32'h108, 32'h108, 32'h8C220004, 32'h12345678, 32'h60},
      '{6'b000000, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 3'b000, 32'h108, 32'h108, 32'h8C220004, 32'h12345678, 32'h200},
      '{6'b000011, 2'b01, 1'b0, 32'h7, 32'h0, 1'b0, 32'h0, 3'b000, 32'h108, 32'h200, 32'h8C220004, 32'h12345678, 32'h7},
      '{6'b000010, 2'b01, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, 3'b000, 32'h200, 32'h200, 32'h8C220004, 32'h12345678, 32'h300},
      '{6'b000100, 2'b00, 1'b0, 32'h10000004, 32'h0, 1'b0, 32'h0, 3'b000, 32'h200, 32'h10000004, 32'h8C220004, 32'h12345678, 32'h10000004},
      '{6'b100100, 2'b00, 1'b0, 32'h10000008, 32'h0, 1'b1, 32'h08000040, 3'b100, 32'h10000004, 32'h10000008, 32'h08000040, 32'h12345678, 32'h10000008},
      '{6'b000100, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h10000008, 32'h10000100, 32'h08000040, 32'h12345678, 32'h0},
      '{6'b000000, 2'b00, 1'b0, 32'h5, 32'h0, 1'b1, 32'hABCD, 3'b000, 32'h10000100, 32'h10000100, 32'h08000040, 32'h12345678, 32'h5},
      '{6'b110000, 2'b00, 1'b0, 32'h6, 32'h0, 1'b1, 32'h20, 3'b100, 32'h10000100, 32'h10000100, 32'h20, 32'h12345678, 32'h6},
      '{6'b101000, 2'b00, 1'b0, 32'h7, 32'h11, 1'b0, 32'h0, 3'b101, 32'h10000100, 32'h10000100, 32'h20, 32'h12345678, 32'h6},
      '{6'b101000, 2'b00, 1'b0, 32'h8, 32'h11, 1'b1, 32'h24, 3'b100, 32'h10000100, 32'h10000100, 32'h24, 32'h12345678, 32'h8}
    };
    reset = 1'b1;
    drive(6'b0, 2'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", req, 32'h0);
    chk("rst_stall", stall, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_bus_err", bus_err, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].ctl, tv[i].sel, tv[i].as, tv[i].alu, tv[i].wd, tv[i].ack, tv[i].rd);
      #2;
      chk($sformatf("v%0d_req", i), req, tv[i].e_rws[2]);
      chk($sformatf("v%0d_we", i), we, tv[i].e_rws[1]);
      chk($sformatf("v%0d_stall", i), stall, tv[i].e_rws[0]);
      chk($sformatf("v%0d_addr", i), addr, tv[i].e_addr);
      chk($sformatf("v%0d_wdata", i), wdata, tv[i].wd);
      tick();
      chk($sformatf("v%0d_pc", i), pc, tv[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr, tv[i].e_ir);
      chk($sformatf("v%0d_mdr", i), mdr, tv[i].e_mdr);
      chk($sformatf("v%0d_alu_out", i), alu_out, tv[i].e_alu);
      if (i == 0) begin
        chk("v0_opcode", opcode, 32'h23);
        chk("v0_rt", rt, 32'h2);
        chk("v0_imm", imm, 32'h4);
      end
    end

    // reset while a fetch is pending in BUSY
    do_reset();
    drive(6'b100000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    #2;
    chk("busy_req", req, 32'h1);
    chk("busy_stall", stall, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_req", req, 32'h0);
    chk("midrst_stall", stall, 32'h0);
    chk("midrst_pc", pc, 32'h100);
    tick();
    reset = 1'b0;
    drive(6'b0, 2'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("postrst_req", req, 32'h0);

    do_reset();
    for (int t = 0; t < 300; t++) begin
      int k, wt;
      logic rf, rl, rs_, ren, rbr, rz, ras, acc, rk, est;
      logic [1:0] rsel;
      logic [31:0] rwd, ral, rrd;
      k = $urandom_range(0, 5);
      wt = $urandom_range(0, 3);
      rf = (k == 1) || (k == 4) || (k == 5);
      rl = (k == 2) || (k == 4);
      rs_ = (k == 3) || (k == 5);
      acc = k != 0;
      ren = 1'($urandom_range(0, 1)); rbr = 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1)); ras = 1'($urandom_range(0, 1));
      rsel = 2'($urandom_range(0, 3)); rwd = $urandom;
      for (int c = 0; c <= (acc ? wt : 0); c++) begin
        rk = acc ? (c == wt) : 1'($urandom_range(0, 1));
        ral = $urandom; rrd = $urandom;
        drive({rf, rl, rs_, ren, rbr, rz}, rsel, ras, ral, rwd, rk, rrd);
        #2;
        est = acc && !rk;
        chk("rnd_req", req, acc);
        chk("rnd_we", we, rs_ && !rf);
        chk("rnd_addr", addr, ras ? m_alu : m_pc);
        chk("rnd_wdata", wdata, rwd);
        chk("rnd_stall", stall, est);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_instr", instr, m_ir);
        chk("rnd_opcode", opcode, m_ir[31:26]);
        chk("rnd_rs", rs, m_ir[25:21]);
        chk("rnd_rd", rdf, m_ir[15:11]);
        chk("rnd_funct", funct, m_ir[5:0]);
        chk("rnd_mdr", mdr, m_mdr);
        chk("rnd_alu_out", alu_out, m_alu);
        chk("rnd_bus_err", bus_err, 32'h0);
        case (rsel)
          2'd0: nxt_pc = ral;
          2'd1: nxt_pc = m_alu;
          2'd2: nxt_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
          default: nxt_pc = m_pc;
        endcase
        if ((ren || (rbr && rz)) && !est) m_pc = nxt_pc;
        if (acc && rk) begin
          if (rf) m_ir = rrd;
          else if (rl) m_mdr = rrd;
        end
        if (!est) m_alu = ral;
        tick();
      end
    end

`ifdef FETCH_MEM_TIMEOUT_EN
    do_reset();
    drive(6'b100000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF0000);
    tick();
    chk("to_pre_instr", instr, 32'hFFFF0000);
    for (int c = 0; c < 5; c++) begin
      drive(6'b100000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #2;
      chk($sformatf("to_req_c%0d", c), req, 32'h1);
      chk($sformatf("to_stall_c%0d", c), stall, (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("to_err_c%0d", c), bus_err, 32'h0);
      tick();
    end
    chk("to_instr_nop", instr, 32'h0);
    chk("to_bus_err", bus_err, 32'h1);
    drive(6'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("to_req_dropped", req, 32'h0);
    tick();
    tick();
    chk("to_bus_err_sticky", bus_err, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Datapath front end of the multicycle MIPS core; feeds the control unit.
- Consumes the control unit's PC, branch, memory and instruction-register controls.
- Holds PC, IR, MDR and the ALUOut register, and drives the single shared instruction/data memory port with a req/ack handshake.
- Produces opcode/function and instruction fields, plus a stall that freezes the control FSM until memory completes.

Parameters:
DATA_WIDTH_P, 32, datapath/address width (fixed 32 for field slicing)
RESET_PC_P, 32'h0000_0000, PC value on reset
TIMEOUT_CYCLES_P, 255, max BUSY cycles before abort (only with macro)

Ports:
clk  in  1  core clock
reset  in  1  async active-high reset
i_enable_pc  in  1  unconditional PC write
i_branch  in  1  conditional PC write when i_alu_zero
i_pc_next_sel  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 hold
i_alu_zero  in  1  ALU zero flag
i_alu_result  in  32  combinational ALU result
i_instr_data_addr_sel  in  1  0 address=PC, 1 address=alu_out
i_instr_wr_en  in  1  fetch: read memory, load IR
i_instr_data_wr_en  in  1  data store
i_mem_read_en  in  1  data load, load MDR
i_wr_data  in  32  store data (register B)
o_mem_req  out  1  memory request
o_mem_we  out  1  write strobe
o_mem_addr  out  32  byte address
o_mem_wdata  out  32  write data
i_mem_ack  in  1  access complete; rdata valid this cycle
i_mem_rdata  in  32  read data
o_stall  out  1  control FSM must hold state
o_pc  out  32  current PC
o_instr  out  32  IR
o_opcode  out  6  IR[31:26]
o_function  out  6  IR[5:0]
o_rs/o_rt/o_rd  out  5 each  IR[25:21]/[20:16]/[15:11]
o_imm  out  16  IR[15:0]
o_mem_data  out  32  MDR
o_alu_out  out  32  ALUOut register
o_bus_err  out  1  sticky timeout flag

Behaviour:
- Reset is async. On reset: PC=RESET_PC_P; IR=0, MDR=0, ALUOut=0; FSM=IDLE; o_mem_req=0, o_stall=0, o_bus_err=0.
- A mid-access reset drops o_mem_req in the same cycle.
- access = i_instr_wr_en | i_mem_read_en | i_instr_data_wr_en. Fetch and data access together is illegal; fetch wins.
- o_stall = access & ~(ack accepted this cycle). This is combinational, so a zero-wait ack gives no stall.
- FSM states: IDLE, BUSY.
- IDLE:
  - If access, o_mem_req=1 with addr/we/wdata driven combinationally from inputs.
  - On i_mem_ack in the same cycle, complete and stay in IDLE.
  - Otherwise capture addr/we/wdata into hold registers and go to BUSY.
- BUSY:
  - o_mem_* driven from the hold registers and held stable until ack.
  - On i_mem_ack, complete and return to IDLE.
- Completion: IR<=i_mem_rdata if fetch; MDR<=i_mem_rdata if load; stores load nothing.
- i_mem_ack while o_mem_req=0 is ignored.
- o_mem_addr = i_instr_data_addr_sel ? alu_out : PC; o_mem_we = i_instr_data_wr_en.
- ALUOut <= i_alu_result every cycle except when o_stall=1, where it holds.
- PC write:
  - pc_we = (i_enable_pc | (i_branch & i_alu_zero)) & ~o_stall.
  - Next PC per i_pc_next_sel.
  - Jump target = {PC[31:28], IR[25:0], 2'b00}, formed from the PC already advanced in fetch.
  - Select 11 holds PC.
- PC and IR update on the same edge at fetch completion. 32-bit PC wraps modulo 2^32.

Optional Feature:
- Macro: FETCH_MEM_TIMEOUT_EN.
- Defined:
  - 8-bit-min counter clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES_P without ack: abort (req=0, FSM IDLE), set o_bus_err (sticky until reset), and deassert o_stall that cycle.
  - Aborted fetch loads IR=0 (NOP); aborted load loads MDR=0.
  - Ack in the same cycle as timeout counts as success.
- Undefined: BUSY waits indefinitely; o_bus_err tied 0; no counter logic.

Decomposition:
- Shared package rhodonite_pkg holds:
  - opcode constants (RTYPE, LW, SW, BEQ, ADDI, J)
  - PC_SEL_* encodings
  - IR field bit positions
  - DATA_WIDTH
- One sub-module, mem_handshake: IDLE/BUSY FSM, hold registers, stall generation and the optional timeout. The top module holds PC/IR/MDR/ALUOut and the muxes.

Test Plan:
- Reset with RESET_PC_P=0x100 -> o_pc=0x100, o_mem_req=0, o_instr=0; asserting reset mid-BUSY drops req in the same cycle.
- Fetch, zero-wait ack, rdata=0x8C220004, i_enable_pc=1, sel=00, alu_result=0x104 -> o_stall never 1; next cycle o_pc=0x104, o_opcode=0x23, o_rt=2, o_imm=0x0004.
- Load, addr_sel=1, alu_out=0x40, ack after 3 cycles -> o_stall=1 for 3 cycles; o_mem_addr=0x40 stable; ALUOut and PC frozen; then MDR=rdata.
- Store, wr_data=0xDEADBEEF, ack after 1 wait -> o_mem_we=1 and wdata held 2 cycles; IR/MDR unchanged.
- BEQ, i_branch=1, sel=01, alu_out=0x200: zero=1 -> PC=0x200; zero=0 -> PC unchanged. Jump with PC=0x1000_0008, IR[25:0]=0x40 -> PC=0x1000_0100.
- With FETCH_MEM_TIMEOUT_EN and TIMEOUT_CYCLES_P=4, fetch never acked -> req drops after 4 BUSY cycles, o_bus_err=1 and sticky, IR=0.
